// File: rtl/serv_arb_pkg.sv
// Shared types and constants for the SERV two-master Wishbone arbiter.
//   arb_state_t : arbiter FSM state (IDLE, GNT_I, GNT_D)
//   WB_SEL_ALL  : full-word byte enable driven for instruction fetches
package serv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/serv_arb_watchdog.sv
// Transaction watchdog for serv_bus_arbiter.
// Counts granted cycles without a slave ack; o_hit fires for one cycle when
// the count reaches TIMEOUT, and o_timeout latches until reset.
//   clk        : clock
//   i_rst_n    : synchronous active-low reset
//   i_granted  : arbiter is in a grant state
//   i_wb_ack   : slave ack
//   o_hit      : watchdog expiry this cycle
//   o_timeout  : sticky expiry flag
module serv_arb_watchdog
  import serv_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_granted,
  input  logic i_wb_ack,
  output logic o_hit,
  output logic o_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign o_hit = i_granted && (cnt == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      cnt       <= '0;
      o_timeout <= 1'b0;
    end else begin
      // Expiry ends the grant, so restart from zero rather than wrapping.
      if (!i_granted || o_hit)
        cnt <= '0;
      else if (!i_wb_ack)
        cnt <= cnt + 1'b1;
      if (o_hit)
        o_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/serv_bus_arbiter.sv
// Two-master (SERV ibus/dbus) to one-slave Wishbone-classic arbiter.
// Grant is held from request to ack; round-robin on contention.
// Optional watchdog enabled by defining SERV_ARB_TIMEOUT_EN.
// Ports:
//   clk, i_rst_n             : clock, synchronous active-low reset
//   i_ibus_* / o_ibus_*      : instruction bus (read-only master)
//   i_dbus_* / o_dbus_*      : data bus (read/write master)
//   o_wb_* / i_wb_*          : shared slave port
//   o_timeout                : sticky watchdog flag (SERV_ARB_TIMEOUT_EN only)
module serv_bus_arbiter
  import serv_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack
`ifdef SERV_ARB_TIMEOUT_EN
  ,
  output logic        o_timeout
`endif
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("serv_bus_arbiter: TIMEOUT must be in 1..255");
  end

  arb_state_t state, state_nxt;
  logic       last_d, last_d_nxt;
  logic       wd_hit;

`ifdef SERV_ARB_TIMEOUT_EN
  serv_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_granted(state != IDLE),
    .i_wb_ack (i_wb_ack),
    .o_hit    (wd_hit),
    .o_timeout(o_timeout)
  );
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    case (state)
      IDLE: begin
        if (i_dbus_cyc && (!i_ibus_cyc || !last_d)) begin
          state_nxt  = GNT_D;
          last_d_nxt = 1'b1;
        end else if (i_ibus_cyc) begin
          state_nxt  = GNT_I;
          last_d_nxt = 1'b0;
        end
      end
      // Dropping cyc, a slave ack or watchdog expiry all end the grant.
      GNT_I: if (!i_ibus_cyc || i_wb_ack || wd_hit) state_nxt = IDLE;
      GNT_D: if (!i_dbus_cyc || i_wb_ack || wd_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_wb_adr   = '0;
    o_wb_dat   = '0;
    o_wb_sel   = '0;
    o_wb_we    = 1'b0;
    o_wb_cyc   = 1'b0;
    o_ibus_ack = 1'b0;
    o_dbus_ack = 1'b0;
    case (state)
      GNT_I: begin
        o_wb_adr   = i_ibus_adr;
        o_wb_sel   = WB_SEL_ALL;
        o_wb_cyc   = i_ibus_cyc && !wd_hit;
        o_ibus_ack = i_ibus_cyc && (i_wb_ack || wd_hit);
      end
      GNT_D: begin
        o_wb_adr   = i_dbus_adr;
        o_wb_dat   = i_dbus_dat;
        o_wb_sel   = i_dbus_sel;
        o_wb_we    = i_dbus_we;
        o_wb_cyc   = i_dbus_cyc && !wd_hit;
        o_dbus_ack = i_dbus_cyc && (i_wb_ack || wd_hit);
      end
      default: ;
    endcase
    // State only clears on the reset edge, so mask handshakes while reset is held.
    if (!i_rst_n) begin
      o_wb_cyc   = 1'b0;
      o_ibus_ack = 1'b0;
      o_dbus_ack = 1'b0;
    end
  end

  assign o_ibus_rdt = (wd_hit && state == GNT_I) ? '0 : i_wb_rdt;
  assign o_dbus_rdt = (wd_hit && state == GNT_D) ? '0 : i_wb_rdt;

endmodule

// File: tb/tb_serv_bus_arbiter.sv
module tb_serv_bus_arbiter;

  typedef struct {
    logic        bus;   // 0 = ibus, 1 = dbus
    logic [31:0] rdt;
  } ack_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } slv_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ibus_adr, dbus_adr, dbus_dat;
  logic        ibus_cyc, dbus_cyc, dbus_we;
  logic [3:0]  dbus_sel;
  logic [31:0] o_ibus_rdt, o_dbus_rdt, o_wb_adr, o_wb_dat;
  logic        o_ibus_ack, o_dbus_ack, o_wb_we, o_wb_cyc;
  logic [3:0]  o_wb_sel;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
`ifdef SERV_ARB_TIMEOUT_EN
  logic        o_timeout;
`endif

  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  ack_t exp_ack[$];
  slv_t exp_slv[$];
  int   ack_cyc[$];

  bit          slave_en;
  int          ack_delay;
  logic        man_ack;
  logic [31:0] man_rdt;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  serv_bus_arbiter #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .i_rst_n   (rst_n),
    .i_ibus_adr(ibus_adr),
    .i_ibus_cyc(ibus_cyc),
    .o_ibus_rdt(o_ibus_rdt),
    .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(dbus_adr),
    .i_dbus_dat(dbus_dat),
    .i_dbus_sel(dbus_sel),
    .i_dbus_we (dbus_we),
    .i_dbus_cyc(dbus_cyc),
    .o_dbus_rdt(o_dbus_rdt),
    .o_dbus_ack(o_dbus_ack),
    .o_wb_adr  (o_wb_adr),
    .o_wb_dat  (o_wb_dat),
    .o_wb_sel  (o_wb_sel),
    .o_wb_we   (o_wb_we),
    .o_wb_cyc  (o_wb_cyc),
    .i_wb_rdt  (i_wb_rdt),
    .i_wb_ack  (i_wb_ack)
`ifdef SERV_ARB_TIMEOUT_EN
    ,
    .o_timeout (o_timeout)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_ibus_ack || o_dbus_ack) begin
        lat = i;
        return;
      end
    end
    check("ack_wait_budget", 32'(lat), 32'(budget));
  endtask

  // Slave model: acks ack_delay cycles into o_wb_cyc, rdt derived from address.
  initial begin
    int cnt;
    cnt      = 0;
    i_wb_ack = 1'b0;
    i_wb_rdt = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!slave_en) begin
        i_wb_ack = man_ack;
        i_wb_rdt = man_rdt;
        cnt      = 0;
      end else if (o_wb_cyc) begin
        if (cnt == ack_delay) begin
          i_wb_ack = 1'b1;
          i_wb_rdt = 32'hA5A5_0000 ^ o_wb_adr;
          cnt      = 0;
        end else begin
          i_wb_ack = 1'b0;
          cnt++;
        end
      end else begin
        i_wb_ack = 1'b0;
        cnt      = 0;
      end
    end
  end

  // Monitor: compares every master ack and every slave-side transfer.
  always @(negedge clk) begin : mon
    ack_t a;
    slv_t s;
    if (rst_n) begin
      if (o_ibus_ack || o_dbus_ack) begin
        ack_cyc.push_back(cycle);
        if (exp_ack.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: ibus_ack=%b dbus_ack=%b required none", o_ibus_ack, o_dbus_ack);
        end else begin
          a = exp_ack.pop_front();
          check("ack_bus", 32'({o_dbus_ack, o_ibus_ack}), a.bus ? 32'd2 : 32'd1);
          check("ack_rdt", a.bus ? o_dbus_rdt : o_ibus_rdt, a.rdt);
        end
      end
      if (o_wb_cyc && i_wb_ack) begin
        if (exp_slv.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_slave_xfer: adr=%h required none", o_wb_adr);
        end else begin
          s = exp_slv.pop_front();
          check("slv_adr", o_wb_adr, s.adr);
          check("slv_dat", o_wb_dat, s.dat);
          check("slv_sel", 32'(o_wb_sel), 32'(s.sel));
          check("slv_we", 32'(o_wb_we), 32'(s.we));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: sim time %0t required completion", $time);
    $fatal(1);
  end

  initial begin
    int lat;
    int lats[4];
    rst_n = 1'b0; ibus_adr = '0; ibus_cyc = 1'b0;
    dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
    slave_en = 1'b1; ack_delay = 0; man_ack = 1'b0; man_rdt = '0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_wb_cyc", 32'(o_wb_cyc), 32'd0);
    check("rst_acks", 32'({o_ibus_ack, o_dbus_ack}), 32'd0);
`ifdef SERV_ARB_TIMEOUT_EN
    check("rst_timeout", 32'(o_timeout), 32'd0);
`endif
    step(); rst_n = 1'b1;
    step();

    // ibus fetch, slave acks 3 cycles after seeing cyc
    ack_delay = 3;
    exp_slv.push_back('{adr: 32'h100, dat: 32'h0, sel: 4'hF, we: 1'b0});
    exp_ack.push_back('{bus: 1'b0, rdt: 32'hA5A5_0100});
    step(); ibus_adr = 32'h100; ibus_cyc = 1'b1;
    wait_ack(20, lat);
    check("ibus_latency", 32'(lat), 32'd4);
    step(); ibus_cyc = 1'b0;

    // Continuous contention from reset: D, I, D, I, 3 cycles apart
    step();
    rst_n = 1'b0; ack_delay = 1;
    ibus_adr = 32'h40; dbus_adr = 32'h3000; dbus_dat = 32'h1111_2222; dbus_sel = 4'hF; dbus_we = 1'b0;
    ibus_cyc = 1'b1; dbus_cyc = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_slv.push_back('{adr: 32'h3000, dat: 32'h1111_2222, sel: 4'hF, we: 1'b0});
      exp_ack.push_back('{bus: 1'b1, rdt: 32'hA5A5_3000});
      exp_slv.push_back('{adr: 32'h40, dat: 32'h0, sel: 4'hF, we: 1'b0});
      exp_ack.push_back('{bus: 1'b0, rdt: 32'hA5A5_0040});
    end
    step(); rst_n = 1'b1;
    ack_cyc.delete();
    for (int k = 0; k < 4; k++) wait_ack(20, lats[k]);
    step(); ibus_cyc = 1'b0; dbus_cyc = 1'b0;
    check("rr_first_latency", 32'(lats[0]), 32'd2);
    check("rr_ack_count", 32'(ack_cyc.size()), 32'd4);
    for (int k = 1; k < 4 && k < ack_cyc.size(); k++)
      check("rr_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd3);

    // dbus write
    ack_delay = 0;
    exp_slv.push_back('{adr: 32'h2000, dat: 32'hDEAD_BEEF, sel: 4'h3, we: 1'b1});
    exp_ack.push_back('{bus: 1'b1, rdt: 32'hA5A5_2000});
    step(); dbus_adr = 32'h2000; dbus_dat = 32'hDEAD_BEEF; dbus_sel = 4'h3; dbus_we = 1'b1; dbus_cyc = 1'b1;
    wait_ack(20, lat);
    check("dbus_wr_latency", 32'(lat), 32'd1);
    step(); dbus_cyc = 1'b0; dbus_we = 1'b0;

    // dbus aborts in its second granted cycle while slave acks
    slave_en = 1'b0; man_ack = 1'b0; man_rdt = 32'h1234_5678;
    step(); dbus_adr = 32'h44; dbus_cyc = 1'b1;
    step();
    step(); dbus_cyc = 1'b0; man_ack = 1'b1;
    @(negedge clk);
    check("abort_no_dbus_ack", 32'(o_dbus_ack), 32'd0);
    check("abort_wb_cyc", 32'(o_wb_cyc), 32'd0);
    // FSM must be IDLE now: a fresh ibus request (ack still high) is granted next edge
    exp_slv.push_back('{adr: 32'h80, dat: 32'h0, sel: 4'hF, we: 1'b0});
    exp_ack.push_back('{bus: 1'b0, rdt: 32'h1234_5678});
    step(); ibus_adr = 32'h80; ibus_cyc = 1'b1;
    wait_ack(10, lat);
    check("post_abort_latency", 32'(lat), 32'd1);
    step(); ibus_cyc = 1'b0; man_ack = 1'b0;

    // Reset during GNT_D: no ack, cyc low, and last_d cleared (D wins next contention)
    step(); dbus_adr = 32'h48; dbus_cyc = 1'b1;
    step(); rst_n = 1'b0; man_ack = 1'b1;
    @(negedge clk);
    check("rstd_acks", 32'({o_ibus_ack, o_dbus_ack}), 32'd0);
    check("rstd_wb_cyc", 32'(o_wb_cyc), 32'd0);
    exp_slv.push_back('{adr: 32'h48, dat: 32'hDEAD_BEEF, sel: 4'h3, we: 1'b0});
    exp_ack.push_back('{bus: 1'b1, rdt: 32'hA5A5_0048});
    exp_slv.push_back('{adr: 32'h4C, dat: 32'h0, sel: 4'hF, we: 1'b0});
    exp_ack.push_back('{bus: 1'b0, rdt: 32'hA5A5_004C});
    step(); rst_n = 1'b1; man_ack = 1'b0; slave_en = 1'b1; ack_delay = 0;
    ibus_adr = 32'h4C; ibus_cyc = 1'b1;
    wait_ack(20, lat);
    wait_ack(20, lat);
    step(); ibus_cyc = 1'b0; dbus_cyc = 1'b0;

    // Reset during GNT_I
    slave_en = 1'b0; man_ack = 1'b0;
    step(); ibus_adr = 32'h50; ibus_cyc = 1'b1;
    step(); rst_n = 1'b0; man_ack = 1'b1;
    @(negedge clk);
    check("rsti_ibus_ack", 32'(o_ibus_ack), 32'd0);
    check("rsti_wb_cyc", 32'(o_wb_cyc), 32'd0);
    step(); rst_n = 1'b1; ibus_cyc = 1'b0;
    @(negedge clk);
    check("rsti_idle_wb_cyc", 32'(o_wb_cyc), 32'd0);
    check("rsti_idle_acks", 32'({o_ibus_ack, o_dbus_ack}), 32'd0);
    step(); man_ack = 1'b0;

`ifdef SERV_ARB_TIMEOUT_EN
    // Slave never acks: watchdog acks on the 5th granted cycle with rdt=0
    man_rdt = 32'hFFFF_FFFF;
    exp_ack.push_back('{bus: 1'b0, rdt: 32'h0});
    step(); ibus_adr = 32'h300; ibus_cyc = 1'b1;
    wait_ack(20, lat);
    check("wd_latency", 32'(lat), 32'd5);
    check("wd_wb_cyc_forced", 32'(o_wb_cyc), 32'd0);
    step(); ibus_cyc = 1'b0;
    @(negedge clk);
    check("wd_flag_set", 32'(o_timeout), 32'd1);
    repeat (5) step();
    @(negedge clk);
    check("wd_flag_sticky", 32'(o_timeout), 32'd1);
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    @(negedge clk);
    check("wd_flag_reset", 32'(o_timeout), 32'd0);
`else
    // Without the watchdog a grant waits indefinitely
    man_rdt = 32'hCAFE_F00D;
    exp_slv.push_back('{adr: 32'h300, dat: 32'h0, sel: 4'hF, we: 1'b0});
    exp_ack.push_back('{bus: 1'b0, rdt: 32'hCAFE_F00D});
    step(); ibus_adr = 32'h300; ibus_cyc = 1'b1;
    repeat (30) step();
    @(negedge clk);
    check("nowd_still_granted", 32'(o_wb_cyc), 32'd1);
    step(); man_ack = 1'b1;
    wait_ack(5, lat);
    check("nowd_late_ack", 32'(lat), 32'd0);
    step(); ibus_cyc = 1'b0; man_ack = 1'b0;
`endif

    repeat (3) step();
    check("exp_ack_drained", 32'(exp_ack.size()), 32'd0);
    check("exp_slv_drained", 32'(exp_slv.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
